column_feeder: RTL and testbench
================================

# column_feeder

Serial-to-column front end and drain controller for the 4x4 window shift buffer. It accepts a byte stream over a valid/ready handshake, packs four consecutive bytes into one column (rows 0..3), and writes the column into the shift buffer with a one-cycle write pulse. Once four columns are resident, it drives the buffer's read enable for 16 cycles after every column write, draining each sliding 4x4 window serially. It sits between the input byte source and the shift buffer's writeEn/readEn/main_input pins.

## Interface
- DW, 8, byte width of stream and column rows
- Reset rst is asynchronous and active-high; the clock is clk.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- restart  input  1  synchronous clear: new frame or line, discards buffered columns
- in_valid  input  1  in_data valid
- in_data  input  DW  stream byte
- in_ready  output  1  block accepts a byte this cycle
- col_data  output  4*DW  packed column; row i at [DW*i+DW-1:DW*i]; drives main_input
- col_wr  output  1  one-cycle column write pulse; drives writeEn
- win_rd  output  1  window read enable; drives readEn
- win_out_valid  output  1  win_rd delayed by 1 cycle; qualifies the buffer's registered sb_out
- win_cnt  output  16  number of fully drained windows since reset or restart, wraps at 2^16

## Operation
- States: FILL, WRITE, DRAIN. The reset state is FILL.
- Counters:
  - row_cnt (2 b): byte position in the current column.
  - col_cnt (3 b): resident columns, saturates at 4.
  - rd_cnt (4 b): drain position.
- in_ready = (state==FILL) & ~restart. It is decoded from state; all other outputs are registered.
- FILL:
  - On each in_valid & in_ready, in_data is stored to col_data row row_cnt and row_cnt increments.
  - On the handshake with row_cnt==3, go to WRITE and wrap row_cnt to 0.
- WRITE:
  - col_wr=1 for exactly this cycle, with col_data stable.
  - col_cnt = min(col_cnt+1, 4).
  - Go to DRAIN if the new col_cnt==4; otherwise go to FILL.
- DRAIN:
  - win_rd=1 for 16 consecutive cycles while rd_cnt runs 0..15.
  - At rd_cnt==15: return to FILL and increment win_cnt.
  - The buffer's read index is cleared by the preceding col_wr, so each drain emits buffer[0][0] through buffer[3][3] in order.
- Sliding window: after the first 4 columns, every further column triggers WRITE then a full DRAIN.
- restart (any state):
  - Next state is FILL.
  - Clears row_cnt, col_cnt, rd_cnt and win_cnt.
  - Forces col_wr=0 and win_rd=0 from the next edge.
  - Discards any partial column.
  - col_data contents are left unchanged.
  - A byte presented with restart high is not accepted, because in_ready is 0.
- rst: all state cleared asynchronously, including col_data.
- col_wr and win_rd are never high in the same cycle.

## Timing
- Reset values: in_ready=1, col_data=0, col_wr=0, win_rd=0, win_out_valid=0, win_cnt=0.
- Byte to column write: col_wr is high in the cycle after the 4th byte handshake.
- First window:
  - win_rd rises in the cycle after col_wr and stays high for 16 cycles.
  - win_out_valid is high for 16 cycles, starting one cycle later.
- Per-column throughput once the window is full: 4 (FILL) + 1 (WRITE) + 16 (DRAIN) = 21 cycles minimum.
- While filling the first window, throughput is 5 cycles per column.
- in_ready is 0 throughout WRITE and DRAIN; in_valid may stay high and the byte is held upstream.
- win_cnt updates on the edge that ends the 16th win_rd cycle.
- rst asserted mid-DRAIN: win_rd and win_out_valid drop immediately and asynchronously. The buffer is reset by the same rst.

## Test plan
- Reset, then stream bytes 0x00..0x0F with in_valid held high:
  - col_wr pulses 4 times with col_data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
  - No win_rd until after the 4th col_wr.
  - Then 16 win_rd cycles; sb_out under win_out_valid reads 0x00,0x04,0x08,0x0C,0x01,...,0x0F (row-major buffer order).
  - win_cnt=1.
- Continue with bytes 0x10..0x13:
  - One col_wr with col_data 0x13121110, then 16 win_rd cycles.
  - Window is columns 1..4; the first sb_out is 0x04.
  - win_cnt=2.
- in_valid toggled every other cycle during FILL:
  - Only handshaken bytes are packed; col_data is unchanged by idle cycles.
  - in_ready stays 0 for all 17 WRITE+DRAIN cycles.
- restart after 2 bytes of the 3rd column, then 16 new bytes:
  - The partial column is dropped; col_cnt restarts at 0.
  - The first win_rd comes only after 4 fresh columns; win_cnt shows 1.
- restart asserted at rd_cnt==7 during DRAIN:
  - win_rd is low from the next cycle; win_cnt is cleared; in_ready=1 after restart is deasserted.
- rst pulsed mid-DRAIN:
  - All outputs return to their reset values immediately.
  - 16 bytes after reset produce exactly one window.

Source files
------------

// File: rtl/column_feeder.sv
// Byte-stream to 4-row column packer driving the 4x4 window shift buffer.
// Writes one column per four bytes, then drains a full window once four are resident.
module column_feeder #(
   parameter int DW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            restart,
   input  logic            in_valid,
   input  logic [DW-1:0]   in_data,
   output logic            in_ready,
   output logic [4*DW-1:0] col_data,
   output logic            col_wr,
   output logic            win_rd,
   output logic            win_out_valid,
   output logic [15:0]     win_cnt
);

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      WRITE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t     state;
   logic [1:0] row_cnt;
   logic [2:0] col_cnt;
   logic [3:0] rd_cnt;
   logic       take;

   assign in_ready = (state == FILL) & ~restart;
   assign take     = in_valid & in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= FILL;
         row_cnt       <= '0;
         col_cnt       <= '0;
         rd_cnt        <= '0;
         col_data      <= '0;
         col_wr        <= 1'b0;
         win_rd        <= 1'b0;
         win_out_valid <= 1'b0;
         win_cnt       <= '0;
      end else begin
         win_out_valid <= win_rd;
         if (restart) begin
            // col_data is kept; only the bookkeeping of the frame is dropped
            state   <= FILL;
            row_cnt <= '0;
            col_cnt <= '0;
            rd_cnt  <= '0;
            win_cnt <= '0;
            col_wr  <= 1'b0;
            win_rd  <= 1'b0;
         end else begin
            unique case (state)
               FILL: begin
                  if (take) begin
                     col_data[DW*row_cnt +: DW] <= in_data;
                     row_cnt <= row_cnt + 2'd1;
                     if (row_cnt == 2'd3) begin
                        state  <= WRITE;
                        col_wr <= 1'b1;
                     end
                  end
               end
               WRITE: begin
                  col_wr <= 1'b0;
                  if (col_cnt != 3'd4)
                     col_cnt <= col_cnt + 3'd1;
                  // the column being written makes the window full
                  if (col_cnt >= 3'd3) begin
                     state  <= DRAIN;
                     win_rd <= 1'b1;
                     rd_cnt <= '0;
                  end else begin
                     state <= FILL;
                  end
               end
               DRAIN: begin
                  rd_cnt <= rd_cnt + 4'd1;
                  if (rd_cnt == 4'd15) begin
                     state   <= FILL;
                     win_rd  <= 1'b0;
                     win_cnt <= win_cnt + 16'd1;
                  end
               end
               default: begin
                  state  <= FILL;
                  col_wr <= 1'b0;
                  win_rd <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_column_feeder.sv
// Bench for column_feeder: vector table, directed corner sequences and
// randomized traffic against a token-queue reference model.
module tb_column_feeder;

   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            restart;
   logic            in_valid;
   logic [DW-1:0]   in_data;
   logic            in_ready;
   logic [4*DW-1:0] col_data;
   logic            col_wr;
   logic            win_rd;
   logic            win_out_valid;
   logic [15:0]     win_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   column_feeder #(.DW(DW)) dut (
      .clk           (clk),
      .rst           (rst),
      .restart       (restart),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .col_data      (col_data),
      .col_wr        (col_wr),
      .win_rd        (win_rd),
      .win_out_valid (win_out_valid),
      .win_cnt       (win_cnt)
   );

   // Model: each finished column schedules its future output cycles as tokens
   typedef struct {
      bit wr;
      bit rd;
      bit last;
   } tok_t;

   tok_t        q[$];
   tok_t        cur;
   logic [7:0]  m_col[4];
   int          m_row;
   int          m_cols;
   logic [15:0] m_wcnt;
   bit          m_ov;

   bit          last_rdy;
   bit          last_hs;
   int          n_wr;
   int          n_rd;
   int          run;
   bit          prev_wr;
   logic [31:0] wr_cols[$];

   typedef struct {
      bit          v;
      logic [7:0]  d;
      bit          rdy;
      bit          wr;
      logic [31:0] col;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      cur    = '{0, 0, 0};
      m_row  = 0;
      m_cols = 0;
      m_wcnt = '0;
      m_ov   = 0;
      run    = 0;
      for (int i = 0; i < 4; i++) m_col[i] = '0;
   endtask

   function automatic bit m_ready(input bit rs);
      return !cur.wr && !cur.rd && !rs;
   endfunction

   function automatic logic [31:0] m_word();
      return {m_col[3], m_col[2], m_col[1], m_col[0]};
   endfunction

   task automatic step(input bit rs, input bit v, input logic [7:0] d);
      bit hs;
      restart  = rs;
      in_valid = v;
      in_data  = d;
      #2;
      last_rdy = in_ready;
      chk("in_ready", in_ready, m_ready(rs));
      hs = v && m_ready(rs);
      last_hs = hs;
      @(posedge clk);
      #1;
      m_ov = cur.rd;
      if (rs) begin
         q.delete();
         cur    = '{0, 0, 0};
         m_row  = 0;
         m_cols = 0;
         m_wcnt = '0;
      end else begin
         if (cur.last) m_wcnt++;
         if (hs) begin
            m_col[m_row] = d;
            m_row++;
            if (m_row == 4) begin
               m_row = 0;
               if (m_cols < 4) m_cols++;
               q.push_back('{1, 0, 0});
               if (m_cols == 4)
                  for (int i = 0; i < 16; i++) q.push_back('{0, 1, i == 15});
            end
         end
         cur = (q.size() != 0) ? q.pop_front() : '{0, 0, 0};
      end
      chk("col_wr", col_wr, cur.wr);
      chk("win_rd", win_rd, cur.rd);
      chk("win_out_valid", win_out_valid, m_ov);
      chk("win_cnt", win_cnt, m_wcnt);
      chk("col_data", col_data, m_word());
      if (col_wr === 1'b1) begin
         n_wr++;
         wr_cols.push_back(col_data);
      end
      if (win_rd === 1'b1) begin
         if (run == 0) chk("rd_after_wr", prev_wr, 1);
         n_rd++;
         run++;
      end else begin
         run = 0;
      end
      prev_wr = col_wr;
   endtask

   task automatic feed(input logic [7:0] d);
      int k;
      k = 0;
      do begin
         step(0, 1, d);
         k++;
      end while (!last_hs && k < 64);
      if (!last_hs) chk("feed_timeout", 0, 1);
   endtask

   task automatic drain(output int busy_cycles);
      int k;
      k = 0;
      busy_cycles = 0;
      while ((cur.wr || cur.rd) && k < 64) begin
         step(0, 0, 8'h00);
         if (!last_rdy) busy_cycles++;
         k++;
      end
      if (cur.wr || cur.rd) chk("drain_timeout", 0, 1);
   endtask

   task automatic clear_counts();
      n_wr = 0;
      n_rd = 0;
      wr_cols.delete();
   endtask

   initial begin
      int busy;
      int hs_cnt;

      tbl[0] = '{1, 8'h00, 1, 0, 32'h0000_0000};
      tbl[1] = '{1, 8'h01, 1, 0, 32'h0000_0100};
      tbl[2] = '{1, 8'h02, 1, 0, 32'h0002_0100};
      tbl[3] = '{1, 8'h03, 1, 1, 32'h0302_0100};
      tbl[4] = '{1, 8'h04, 0, 0, 32'h0302_0100};
      tbl[5] = '{1, 8'h04, 1, 0, 32'h0302_0104};

      rst      = 1'b1;
      restart  = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      prev_wr  = 0;
      model_reset();
      clear_counts();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_col_data", col_data, 0);
      chk("rst_col_wr", col_wr, 0);
      chk("rst_win_rd", win_rd, 0);
      chk("rst_win_out_valid", win_out_valid, 0);
      chk("rst_win_cnt", win_cnt, 0);
      rst = 1'b0;

      // First column through the vector table
      for (int i = 0; i < 6; i++) begin
         step(0, tbl[i].v, tbl[i].d);
         chk("tbl_rdy", last_rdy, tbl[i].rdy);
         chk("tbl_wr", col_wr, tbl[i].wr);
         chk("tbl_col", col_data, tbl[i].col);
      end
      for (int b = 5; b < 16; b++) begin
         if (b == 15) chk("no_rd_before_4th_wr", n_rd, 0);
         feed(8'(b));
      end
      drain(busy);
      chk("p1_wr_pulses", n_wr, 4);
      chk("p1_rd_cycles", n_rd, 16);
      chk("p1_win_cnt", win_cnt, 1);
      chk("p1_col0", wr_cols[0], 32'h0302_0100);
      chk("p1_col1", wr_cols[1], 32'h0706_0504);
      chk("p1_col2", wr_cols[2], 32'h0B0A_0908);
      chk("p1_col3", wr_cols[3], 32'h0F0E_0D0C);

      // Sliding window: one more column gives one more full drain
      clear_counts();
      for (int b = 16; b < 20; b++) feed(8'(b));
      drain(busy);
      chk("p2_wr_pulses", n_wr, 1);
      chk("p2_col", wr_cols[0], 32'h1312_1110);
      chk("p2_rd_cycles", n_rd, 16);
      chk("p2_win_cnt", win_cnt, 2);

      // Valid toggling every other cycle
      clear_counts();
      hs_cnt = 0;
      for (int i = 0; i < 40 && hs_cnt < 4; i++) begin
         step(0, i[0], 8'(8'h20 + hs_cnt));
         if (last_hs) hs_cnt++;
      end
      chk("tog_handshakes", hs_cnt, 4);
      drain(busy);
      chk("tog_busy_cycles", busy, 17);
      chk("tog_col", wr_cols[0], 32'h2322_2120);
      chk("tog_win_cnt", win_cnt, 3);

      // Restart with a partial column pending
      feed(8'h30);
      feed(8'h31);
      step(1, 1, 8'h99);
      chk("rs_blocks_byte", last_hs, 0);
      clear_counts();
      for (int b = 0; b < 16; b++) begin
         if (b == 15) chk("rs_no_early_rd", n_rd, 0);
         feed(8'(8'h40 + b));
      end
      drain(busy);
      chk("rs_wr_pulses", n_wr, 4);
      chk("rs_rd_cycles", n_rd, 16);
      chk("rs_win_cnt", win_cnt, 1);

      // Restart in the middle of a drain, at rd_cnt 7
      for (int b = 0; b < 4; b++) feed(8'(8'h50 + b));
      for (int k = 0; k < 40 && run != 8; k++) step(0, 0, 8'h00);
      chk("reach_rd7", run, 8);
      step(1, 0, 8'h00);
      chk("rs7_win_rd", win_rd, 0);
      chk("rs7_win_cnt", win_cnt, 0);
      step(0, 0, 8'h00);
      chk("rs7_in_ready", last_rdy, 1);

      // Asynchronous reset mid-drain
      for (int b = 0; b < 16; b++) feed(8'(8'h60 + b));
      for (int k = 0; k < 40 && run != 5; k++) step(0, 0, 8'h00);
      chk("reach_rd4", run, 5);
      rst = 1'b1;
      #1;
      chk("arst_win_rd", win_rd, 0);
      chk("arst_win_out_valid", win_out_valid, 0);
      chk("arst_col_data", col_data, 0);
      chk("arst_win_cnt", win_cnt, 0);
      chk("arst_in_ready", in_ready, 1);
      model_reset();
      prev_wr = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_counts();
      for (int b = 0; b < 16; b++) feed(8'(8'h70 + b));
      drain(busy);
      chk("arst_rd_cycles", n_rd, 16);
      chk("arst_win_after", win_cnt, 1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++)
         step(($urandom % 64) == 0, $urandom_range(0, 1) == 1, 8'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
